// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit BCD game-timer down counter.
// Loads a clamped BCD value, adds saturating bonus time and counts down on
// qualified ticks. At zero it either holds or reloads all-nines (WRAP).
// expired is a registered one-cycle pulse when a decrement reaches zero.
// Optional feature macro: BCD_TIMER_WARN_EN enables the registered low-time
// warn output. When the macro is undefined, warn is tied low.
module bcd_down_timer #(
  parameter int DIGITS      = 2,
  parameter int WRAP        = 0,
  parameter int WARN_THRESH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadN,
  input  logic                  enable1,
  input  logic                  enable2,
  input  logic                  add_en,
  input  logic [4*DIGITS-1:0]   add_value,
  input  logic [4*DIGITS-1:0]   datain,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  expired,
  output logic                  warn
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ZERO_L  = {W{1'b0}};
  localparam logic [W-1:0] NINES_L = {DIGITS{4'h9}};

  // Limit one BCD digit to the legal range 0..9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      return 4'd9;
    end else begin
      return d;
    end
  endfunction

  // Clamp every digit of a BCD word.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = ZERO_L;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
    end
    return r;
  endfunction

  // BCD ripple add. A carry out of the top digit saturates to all-nines.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    logic [4:0]   s;
    r = ZERO_L;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    if (c) begin
      r = NINES_L;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // BCD decrement with digit-wise borrow. The caller excludes zero.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = ZERO_L;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        d = d;
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  logic           tick_s;
  logic [W-1:0]   base_s;
  logic [W-1:0]   dec_s;
  logic [W-1:0]   count_next_s;
  logic           expired_next_s;
  logic [W-1:0]   count_r;
  logic           expired_r;

  // Next-state selection: load beats add/tick. An add is applied before a
  // same-cycle tick, so no tick is lost.
  always_comb begin
    tick_s         = enable1 & enable2;
    base_s         = count_r;
    dec_s          = ZERO_L;
    count_next_s   = count_r;
    expired_next_s = 1'b0;
    if (!loadN) begin
      count_next_s = clamp_bcd(datain);
    end else begin
      if (add_en) begin
        base_s = sat_add(count_r, clamp_bcd(add_value));
      end else begin
        base_s = count_r;
      end
      dec_s = bcd_dec(base_s);
      if (tick_s) begin
        if (base_s == ZERO_L) begin
          if (WRAP != 0) begin
            count_next_s = NINES_L;
          end else begin
            count_next_s = ZERO_L;
          end
        end else begin
          count_next_s   = dec_s;
          expired_next_s = (dec_s == ZERO_L);
        end
      end else begin
        count_next_s = base_s;
      end
    end
  end

  // Count and expiry pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= ZERO_L;
      expired_r <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      expired_r <= expired_next_s;
    end
  end

  assign count   = count_r;
  assign tc      = (count_r == ZERO_L);
  assign expired = expired_r;

`ifdef BCD_TIMER_WARN_EN
  localparam logic [15:0] WARN_THRESH_L = 16'(WARN_THRESH);

  // Digit-weighted binary value of a BCD word.
  function automatic logic [15:0] bcd_to_bin(input logic [W-1:0] v);
    logic [15:0] acc;
    acc = 16'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * 16'd10 + {12'd0, v[4*i +: 4]};
    end
    return acc;
  endfunction

  logic warn_r;

  // Low-time warning follows the next count so it tracks loads and adds.
  always_ff @(posedge clk) begin
    if (reset) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= (count_next_s != ZERO_L) && (bcd_to_bin(count_next_s) <= WARN_THRESH_L);
    end
  end

  assign warn = warn_r;
`else
  // Warning disabled: constant low; the parameter reference folds away.
  localparam logic WARN_OFF_L = (WARN_THRESH >= 0) & 1'b0;
  assign warn = WARN_OFF_L;
`endif

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of bcd_down_timer with DIGITS = 2.
// u_dut0 holds at zero (WRAP = 0), u_dut1 wraps (WRAP = 1); both share inputs.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadN;
  logic       enable1;
  logic       enable2;
  logic       add_en;
  logic [7:0] add_value;
  logic [7:0] datain;
  logic [7:0] count0, count1;
  logic       tc0, tc1, expired0, expired1, warn0, warn1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                           8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2), .WRAP(0), .WARN_THRESH(5)) u_dut0 (
    .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
    .add_en(add_en), .add_value(add_value), .datain(datain),
    .count(count0), .tc(tc0), .expired(expired0), .warn(warn0)
  );

  bcd_down_timer #(.DIGITS(2), .WRAP(1), .WARN_THRESH(5)) u_dut1 (
    .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
    .add_en(add_en), .add_value(add_value), .datain(datain),
    .count(count1), .tc(tc1), .expired(expired1), .warn(warn1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected warn for a two-digit BCD count with threshold 5.
  function automatic logic exp_warn(input logic [7:0] c);
`ifdef BCD_TIMER_WARN_EN
    int b;
    b = int'(c[7:4]) * 10 + int'(c[3:0]);
    return (c != 8'h00) && (b <= 5);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    loadN  = 1'b0;
    datain = v;
    step();
    loadN  = 1'b1;
  endtask

  initial begin
    reset = 1'b1; loadN = 1'b1; enable1 = 1'b0; enable2 = 1'b0;
    add_en = 1'b0; add_value = 8'h00; datain = 8'h00;
    step();
    step();
    chk("rst_count", count0, 8'h00);
    chk("rst_tc", tc0, 1'b1);
    chk("rst_expired", expired0, 1'b0);
    chk("rst_warn", warn0, 1'b0);
    reset = 1'b0;

    load(8'h12);
    chk("load_12", count0, 8'h12);
    chk("load_12_tc", tc0, 1'b0);

    // enable1 alone is not a tick
    enable1 = 1'b1;
    step();
    chk("no_tick_game_stopped", count0, 8'h12);

    enable2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("down_%0d", i), count0, seq[i]);
      chk($sformatf("down_exp_%0d", i), expired0, (i == 11) ? 1'b1 : 1'b0);
      chk($sformatf("down_warn_%0d", i), warn0, exp_warn(seq[i]));
    end
    chk("zero_tc", tc0, 1'b1);
    chk("wrap_inst_exp", expired1, 1'b1);

    step();
    chk("hold_zero", count0, 8'h00);
    chk("hold_no_pulse", expired0, 1'b0);
    chk("hold_tc", tc0, 1'b1);
    chk("wrap_99", count1, 8'h99);
    chk("wrap_no_pulse", expired1, 1'b0);
    step();
    chk("hold_zero2", count0, 8'h00);
    chk("hold_no_pulse2", expired0, 1'b0);
    chk("wrap_98", count1, 8'h98);
    enable2 = 1'b0;

    load(8'h3F);
    chk("clamp_3F", count0, 8'h39);

    load(8'h20);
    enable2 = 1'b1;
    step();
    enable2 = 1'b0;
    chk("borrow_20", count0, 8'h19);

    load(8'h85);
    add_en = 1'b1; add_value = 8'h27;
    step();
    add_en = 1'b0;
    chk("sat_add", count0, 8'h99);

    load(8'h15);
    add_en = 1'b1; add_value = 8'h05;
    step();
    add_en = 1'b0;
    chk("add_carry", count0, 8'h20);

    load(8'h00);
    chk("load_zero", count0, 8'h00);
    chk("load_zero_exp", expired0, 1'b0);
    add_en = 1'b1; add_value = 8'h03; enable2 = 1'b1;
    step();
    add_en = 1'b0; enable2 = 1'b0;
    chk("add_tick", count0, 8'h02);
    chk("add_tick_exp", expired0, 1'b0);

    load(8'h01);
    enable2 = 1'b1;
    load(8'h50);
    enable2 = 1'b0;
    chk("load_over_tick", count0, 8'h50);
    chk("load_over_tick_exp", expired0, 1'b0);

    load(8'h03);
    chk("warn_at_03", warn0, exp_warn(8'h03));
    add_en = 1'b1; add_value = 8'h10;
    step();
    add_en = 1'b0;
    chk("add_13", count0, 8'h13);
    chk("add_13_warn", warn0, 1'b0);

    load(8'h40);
    enable2 = 1'b1;
    step();
    chk("tick_40", count0, 8'h39);
    reset = 1'b1;
    step();
    reset = 1'b0; enable2 = 1'b0;
    chk("mid_reset", count0, 8'h00);
    chk("mid_reset_wrap", count1, 8'h00);
    chk("mid_reset_exp", expired0, 1'b0);
    chk("mid_reset_warn", warn0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
